// File: rtl/clkdiv_ctrl.sv
// rtl/clkdiv_ctrl.sv - round-robin reconfiguration sequencer for the integer clock divider
// Optional macro CLKDIV_CTRL_SKIP_SAME_EN: acknowledge at once when the locked ratio already matches.
module clkdiv_ctrl #(
  parameter int              Width         = 8,
  parameter int              SETTLE_CYCLES = 4,
  parameter logic [Width-1:0] DEFAULT_RATIO = 'd2
) (
  input  logic             i_ref_clk,
  input  logic             i_rst,
  input  logic [1:0]       i_req,
  input  logic [Width-1:0] i_req0_ratio,
  input  logic [Width-1:0] i_req1_ratio,
  output logic [1:0]       o_ack,
  output logic             o_busy,
  output logic             o_owner,
  output logic             o_clk_en,
  output logic [Width-1:0] o_div_ratio,
  output logic             o_lock
);

  typedef enum logic [2:0] {IDLE, DRAIN, LOAD, WAIT, DONE} state_t;

  localparam logic [Width:0] SETTLE_INIT = (Width+1)'(SETTLE_CYCLES - 1);
  localparam logic [Width:0] CNT_ONE     = (Width+1)'(1);

  state_t           state, state_nxt;
  logic [Width:0]   cnt, cnt_nxt;
  logic [Width-1:0] r_ratio, r_ratio_nxt;
  logic [Width-1:0] div_nxt;
  logic [Width-1:0] win_ratio;
  logic [Width:0]   wait_len;
  logic [1:0]       ack_nxt;
  logic             ptr, ptr_nxt;
  logic             winner, owner_nxt, busy_nxt, en_nxt, lock_nxt;
  logic             bypass, skip;

  // Contended grants go to the pointer; a lone request wins outright.
  assign winner    = (i_req == 2'b11) ? ptr : i_req[1];
  assign win_ratio = winner ? i_req1_ratio : i_req0_ratio;

  // Ratios 0 and 1 bypass the divider: no enable, one-cycle stabilisation wait.
  assign bypass   = (r_ratio[Width-1:1] == '0);
  assign wait_len = bypass ? CNT_ONE : {r_ratio, 1'b0};

`ifdef CLKDIV_CTRL_SKIP_SAME_EN
  assign skip = (win_ratio == o_div_ratio) && o_lock;
`else
  assign skip = 1'b0;
`endif

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    r_ratio_nxt = r_ratio;
    ptr_nxt     = ptr;
    owner_nxt   = o_owner;
    busy_nxt    = o_busy;
    en_nxt      = o_clk_en;
    div_nxt     = o_div_ratio;
    lock_nxt    = o_lock;
    ack_nxt     = 2'b00;
    case (state)
      IDLE: begin
        if (i_req != 2'b00) begin
          ptr_nxt   = ~winner;
          owner_nxt = winner;
          busy_nxt  = 1'b1;
          if (skip) begin
            ack_nxt   = winner ? 2'b10 : 2'b01;
            state_nxt = DONE;
          end else begin
            r_ratio_nxt = win_ratio;
            en_nxt      = 1'b0;
            lock_nxt    = 1'b0;
            cnt_nxt     = SETTLE_INIT;
            state_nxt   = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (cnt == '0) state_nxt = LOAD;
        else           cnt_nxt   = cnt - CNT_ONE;
      end
      LOAD: begin
        // The ratio only ever changes here, while the enable is still low.
        div_nxt   = r_ratio;
        en_nxt    = ~bypass;
        cnt_nxt   = wait_len - CNT_ONE;
        state_nxt = WAIT;
      end
      WAIT: begin
        if (cnt == '0) begin
          lock_nxt  = 1'b1;
          ack_nxt   = o_owner ? 2'b10 : 2'b01;
          state_nxt = DONE;
        end else begin
          cnt_nxt = cnt - CNT_ONE;
        end
      end
      DONE: begin
        busy_nxt  = 1'b0;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_ref_clk or posedge i_rst) begin
    if (i_rst) begin
      state       <= IDLE;
      cnt         <= '0;
      r_ratio     <= DEFAULT_RATIO;
      ptr         <= 1'b0;
      o_owner     <= 1'b0;
      o_busy      <= 1'b0;
      o_clk_en    <= 1'b0;
      o_div_ratio <= DEFAULT_RATIO;
      o_lock      <= 1'b0;
      o_ack       <= 2'b00;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      r_ratio     <= r_ratio_nxt;
      ptr         <= ptr_nxt;
      o_owner     <= owner_nxt;
      o_busy      <= busy_nxt;
      o_clk_en    <= en_nxt;
      o_div_ratio <= div_nxt;
      o_lock      <= lock_nxt;
      o_ack       <= ack_nxt;
    end
  end

endmodule

// File: tb/tb_clkdiv_ctrl.sv
// tb/tb_clkdiv_ctrl.sv - scoreboard bench for clkdiv_ctrl
module tb_clkdiv_ctrl;

  typedef struct {
    logic [1:0] ack;
    logic [7:0] ratio;
    logic       en;
    logic       owner;
    int         cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] i_req;
  logic [7:0] i_req0_ratio, i_req1_ratio;
  logic [1:0] o_ack;
  logic       o_busy, o_owner, o_clk_en, o_lock;
  logic [7:0] o_div_ratio;

  exp_t q[$];
  exp_t e;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   s, s2;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  clkdiv_ctrl #(.Width(8), .SETTLE_CYCLES(4), .DEFAULT_RATIO(8'd2)) dut (
    .i_ref_clk(clk),
    .i_rst(rst),
    .i_req(i_req),
    .i_req0_ratio(i_req0_ratio),
    .i_req1_ratio(i_req1_ratio),
    .o_ack(o_ack),
    .o_busy(o_busy),
    .o_owner(o_owner),
    .o_clk_en(o_clk_en),
    .o_div_ratio(o_div_ratio),
    .o_lock(o_lock)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input logic [1:0] a, input int r, input logic en, input logic own, input int c);
    exp_t x;
    x.ack = a; x.ratio = r[7:0]; x.en = en; x.owner = own; x.cyc = c;
    q.push_back(x);
  endtask

  task automatic wait_ack(input int idx);
    int k;
    k = 0;
    while (!o_ack[idx] && k < 300) begin
      @(negedge clk);
      k++;
    end
    chk("ack_seen", int'(o_ack[idx]), 1);
    i_req[idx] = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst && o_ack != 2'b00) begin
      if (q.size() == 0) begin
        chk("unexpected_ack", int'(o_ack), 0);
      end else begin
        e = q.pop_front();
        chk("ack_value", int'(o_ack), int'(e.ack));
        chk("ack_cycle", cyc, e.cyc);
        chk("ack_ratio", int'(o_div_ratio), int'(e.ratio));
        chk("ack_clk_en", int'(o_clk_en), int'(e.en));
        chk("ack_owner", int'(o_owner), int'(e.owner));
        chk("ack_lock", int'(o_lock), 1);
        chk("ack_busy", int'(o_busy), 1);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; i_req = 2'b00; i_req0_ratio = 8'd0; i_req1_ratio = 8'd0;
    repeat (3) @(negedge clk);
    chk("rst_clk_en", int'(o_clk_en), 0);
    chk("rst_div_ratio", int'(o_div_ratio), 2);
    chk("rst_ack", int'(o_ack), 0);
    chk("rst_busy", int'(o_busy), 0);
    chk("rst_owner", int'(o_owner), 0);
    chk("rst_lock", int'(o_lock), 0);
    rst = 1'b0;
    @(negedge clk);

    // Both requesting with pointer at 0: 0 first (4+12+1), then 1 (4+6+1 after its own sample).
    i_req0_ratio = 8'd6; i_req1_ratio = 8'd3; i_req = 2'b11;
    s = cyc + 1;
    push(2'b01, 6, 1'b1, 1'b0, s + 17);
    push(2'b10, 3, 1'b1, 1'b1, s + 30);
    wait_ack(0);
    wait_ack(1);
    @(negedge clk);
    chk("owner_after_both", int'(o_owner), 1);
    @(negedge clk);

    // Ratio 4: enable low through DRAIN and LOAD, then high with the new ratio.
    i_req0_ratio = 8'd4; i_req = 2'b01;
    s = cyc + 1;
    push(2'b01, 4, 1'b1, 1'b0, s + 13);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("settle_clk_en_low", int'(o_clk_en), 0);
    end
    @(negedge clk);
    chk("load_clk_en", int'(o_clk_en), 1);
    chk("load_div_ratio", int'(o_div_ratio), 4);
    chk("wait_lock_low", int'(o_lock), 0);
    wait_ack(0);
    @(negedge clk);
    chk("idle_lock_held", int'(o_lock), 1);

    // Same ratio again while locked.
    i_req0_ratio = 8'd4; i_req = 2'b01;
    s = cyc + 1;
`ifdef CLKDIV_CTRL_SKIP_SAME_EN
    push(2'b01, 4, 1'b1, 1'b0, s);
    @(negedge clk);
    chk("same_ratio_clk_en", int'(o_clk_en), 1);
`else
    push(2'b01, 4, 1'b1, 1'b0, s + 13);
    @(negedge clk);
    chk("same_ratio_clk_en", int'(o_clk_en), 0);
`endif
    wait_ack(0);
    @(negedge clk);

    // Bypass ratio 1: enable stays low, ack at 4+1+1.
    i_req0_ratio = 8'd1; i_req = 2'b01;
    s = cyc + 1;
    push(2'b01, 1, 1'b0, 1'b0, s + 6);
    wait_ack(0);
    @(negedge clk);

    // Request dropped during DRAIN still completes, with no second grant.
    i_req0_ratio = 8'd5; i_req = 2'b01;
    s = cyc + 1;
    push(2'b01, 5, 1'b1, 1'b0, s + 15);
    @(negedge clk);
    i_req = 2'b00;
    chk("drop_busy", int'(o_busy), 1);
    wait_ack(0);
    repeat (4) @(negedge clk);
    chk("drop_no_regrant", int'(o_busy), 0);

    // Reset during WAIT aborts; held request restarts after release.
    i_req0_ratio = 8'd4; i_req = 2'b01;
    s = cyc + 1;
    while (cyc < s + 8) @(negedge clk);
    chk("pre_rst_busy", int'(o_busy), 1);
    rst = 1'b1;
    #1;
    chk("abort_clk_en", int'(o_clk_en), 0);
    chk("abort_div_ratio", int'(o_div_ratio), 2);
    chk("abort_ack", int'(o_ack), 0);
    chk("abort_busy", int'(o_busy), 0);
    chk("abort_lock", int'(o_lock), 0);
    chk("abort_owner", int'(o_owner), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    s2 = cyc + 1;
    push(2'b01, 4, 1'b1, 1'b0, s2 + 13);
    wait_ack(0);

    repeat (5) @(negedge clk);
    chk("queue_empty", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/clkdiv_ctrl.md
Name: clkdiv_ctrl

Overview:
- Reconfiguration sequencer and arbiter for the integer clock divider.
- Two requesters (e.g. UART TX/RX prescale logic) each ask for a new division ratio. The block grants one at a time, round-robin.
- For each grant it disables the divider, settles, loads the new ratio, re-enables, and waits for the divided clock to stabilise before acknowledging.
- It drives the divider's clock-enable and ratio inputs directly, in the i_ref_clk domain.

Parameters:
- Width, 8, ratio width; matches the divider's ratio input.
- SETTLE_CYCLES, 4, i_ref_clk cycles with enable low before a new ratio is loaded; legal range 1..15.
- DEFAULT_RATIO, 'd2, value driven on o_div_ratio out of reset.

Ports:
- i_ref_clk  in  1  reference clock; the only clock.
- i_rst  in  1  asynchronous, active-high reset.
- i_req  in  2  per-requester request level; bit n = requester n.
- i_req0_ratio  in  Width  ratio wanted by requester 0; stable while i_req[0] is high.
- i_req1_ratio  in  Width  ratio wanted by requester 1; stable while i_req[1] is high.
- o_ack  out  2  one-cycle completion pulse to the granted requester.
- o_busy  out  1  high from grant until the ack cycle inclusive.
- o_owner  out  1  index of the last granted requester.
- o_clk_en  out  1  to divider clock enable.
- o_div_ratio  out  Width  to divider ratio input.
- o_lock  out  1  divided clock stable at o_div_ratio.

Behaviour:
- Reset (async, active-high), for the whole duration of i_rst:
  - state=IDLE, o_clk_en=0, o_div_ratio=DEFAULT_RATIO, o_ack=0, o_busy=0, o_owner=0, o_lock=0, rr pointer=0.
  - Reset mid-sequence aborts immediately; no ack is issued. A still-high i_req is re-sampled in IDLE after release.
- States: IDLE, DRAIN, LOAD, WAIT, DONE.
- IDLE (o_busy=0):
  - If any i_req bit is high at an edge: grant, latch the owner's ratio into r_ratio, set o_owner, o_busy=1, o_clk_en=0, o_lock=0, cnt=SETTLE_CYCLES-1, go to DRAIN.
  - Arbitration: one request wins alone. When both are high, the requester equal to the rr pointer wins. The pointer becomes ~winner at each grant.
- DRAIN:
  - cnt decrements each cycle.
  - At cnt==0, go to LOAD.
  - Duration: SETTLE_CYCLES cycles.
- LOAD (1 cycle):
  - o_div_ratio<=r_ratio.
  - o_clk_en<=(r_ratio>=2); ratios 0 and 1 are bypass and leave enable low.
  - cnt<=Wt-1, where Wt=2*r_ratio, or Wt=1 for bypass.
  - Go to WAIT.
  - o_div_ratio changes only here, always while o_clk_en=0.
- WAIT:
  - Counts Wt cycles, i.e. two full divided periods.
  - cnt is Width+1 bits wide (max 2*(2^Width-1)), with no wrap.
  - Then go to DONE with o_lock<=1 and o_ack[o_owner]<=1.
- DONE (1 cycle):
  - o_ack high for exactly this cycle.
  - Next edge: o_ack=0, o_busy=0, go to IDLE.
- Latency: o_ack is high in the cycle following edge S+Wt+1, counted from the sampling edge (S=SETTLE_CYCLES).
- Requester rules:
  - Hold i_req until ack. Dropping i_req mid-sequence does not abort; the sequence completes and the ack still pulses.
  - i_req still high in the cycle after DONE is treated as a new request.
  - i_req and ratio inputs are ignored outside IDLE; a second requester waits.
- o_lock stays 1 in IDLE until the next grant.

Optional Feature:
- Macro: CLKDIV_CTRL_SKIP_SAME_EN.
- Defined: in IDLE, if the winner's ratio equals o_div_ratio and o_lock==1, go directly to DONE.
  - o_clk_en, o_div_ratio and o_lock are untouched.
  - Ack arrives in the cycle after the sampling edge.
  - Arbitration and pointer update are unchanged.
- Undefined: every grant runs the full DRAIN/LOAD/WAIT sequence.

Test Plan:
- Reset, then i_req=2'b01, ratio0=4 (S=4) -> o_clk_en low for 5 cycles, o_div_ratio=4 with o_clk_en=1 after LOAD, o_ack=2'b01 one cycle at sample+13, o_lock=1.
- Both requests high, ratio0=6, ratio1=3, pointer=0 -> requester 0 served first (ack at +17), then requester 1 (ratio 3, ack 11 cycles after its sampling edge), o_owner 0 then 1.
- Request ratio 1 -> o_clk_en stays 0, o_div_ratio=1, ack at sample+6.
- i_rst asserted during WAIT -> all outputs at reset values immediately, no ack; i_req held high -> new sequence after release.
- i_req[0] dropped during DRAIN -> sequence completes, o_ack[0] still pulses, no second grant.
- With CLKDIV_CTRL_SKIP_SAME_EN defined, after locking at 4, re-request ratio 4 -> ack next cycle, o_clk_en never drops. Macro undefined -> full 13-cycle sequence.
